// File: rtl/maze_scoreboard.sv
// Multi-channel maze scoreboard: per-player timer, crash counter and IDLE/RUN/DONE state.
// Define MAZE_BEST_TIME_EN to keep a per-channel best time in register field 2.
module maze_scoreboard #(
    parameter int CHANNELS   = 2,
    parameter int TIMER_BITS = 20,
    parameter int CRASH_BITS = 8,
    parameter int PRESCALE   = 1000,
    parameter int DEBOUNCE   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CHANNELS-1:0]            crash_in,
    input  logic [CHANNELS-1:0]            goal_in,
    input  logic                           valid,
    input  logic [3:0]                     wstrb,
    input  logic [3:0]                     addr,
    input  logic [31:0]                    wdata,
    output logic                           ready,
    output logic [31:0]                    rdata,
    output logic [CHANNELS*TIMER_BITS-1:0] timer_count,
    output logic [CHANNELS*CRASH_BITS-1:0] crash_count,
    output logic [CHANNELS-1:0]            running,
    output logic [CHANNELS-1:0]            done,
    output logic                           reset_out
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [PS_W-1:0]                presc;
    logic                           tick;
    logic                           access;
    logic                           ctrl_write;
    logic [CHANNELS-1:0]            idle;
    logic [CHANNELS*TIMER_BITS-1:0] best_flat;
    logic [31:0]                    rd_val;
    logic                           unused_wdata;

    assign tick         = (presc == PS_W'(PRESCALE - 1));
    assign access       = valid && !ready;
    assign ctrl_write   = access && (|wstrb) && (addr[1:0] == 2'd3) && wdata[0];
    assign unused_wdata = ^wdata[31:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (start || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [1:0]            crash_sync;
        logic                  crash_db;
        logic [DB_W-1:0]       db_cnt;
        logic [2:0]            goal_sync;
        logic                  crash_event;
        logic                  goal_event;
        logic                  clear;
        state_t                state;
        logic [TIMER_BITS-1:0] timer_q;
        logic [TIMER_BITS-1:0] timer_next;
        logic [CRASH_BITS-1:0] crash_q;
        logic [CRASH_BITS-1:0] crash_next;

        // The crash event fires on the same edge that the debounced level falls.
        assign crash_event = !crash_sync[1] && crash_db && (db_cnt == DB_W'(DEBOUNCE - 1));
        assign goal_event  = goal_sync[1] && !goal_sync[2];
        assign clear       = ctrl_write && (addr[3:2] == 2'(g));
        assign timer_next  = (tick && timer_q != '1) ? timer_q + 1'b1 : timer_q;
        assign crash_next  = (crash_event && crash_q != '1) ? crash_q + 1'b1 : crash_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                crash_sync <= 2'b11;
                crash_db   <= 1'b1;
                db_cnt     <= '0;
                goal_sync  <= 3'b000;
            end else begin
                crash_sync <= {crash_sync[0], crash_in[g]};
                goal_sync  <= {goal_sync[1:0], goal_in[g]};
                if (crash_sync[1] == crash_db) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                    crash_db <= crash_sync[1];
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= IDLE;
                timer_q <= '0;
                crash_q <= '0;
            end else if (clear) begin
                state   <= IDLE;
                timer_q <= '0;
                crash_q <= '0;
            end else if (start) begin
                state   <= RUN;
                timer_q <= '0;
                crash_q <= '0;
            end else if (state == RUN) begin
                timer_q <= timer_next;
                crash_q <= crash_next;
                if (goal_event) begin
                    state <= DONE;
                end
            end
        end

`ifdef MAZE_BEST_TIME_EN
        logic [TIMER_BITS-1:0] best_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                best_q <= '1;
            end else if (!clear && !start && state == RUN && goal_event && timer_next < best_q) begin
                best_q <= timer_next;
            end
        end

        assign best_flat[g*TIMER_BITS +: TIMER_BITS] = best_q;
`else
        assign best_flat[g*TIMER_BITS +: TIMER_BITS] = '0;
`endif

        assign timer_count[g*TIMER_BITS +: TIMER_BITS] = timer_q;
        assign crash_count[g*CRASH_BITS +: CRASH_BITS] = crash_q;
        assign running[g] = (state == RUN);
        assign done[g]    = (state == DONE);
        assign idle[g]    = (state == IDLE);
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (addr[3:2] == 2'(c)) begin
                case (addr[1:0])
                    2'd0:    rd_val = 32'(timer_count[c*TIMER_BITS +: TIMER_BITS]);
                    2'd1:    rd_val = 32'(crash_count[c*CRASH_BITS +: CRASH_BITS]);
                    2'd2:    rd_val = 32'(best_flat[c*TIMER_BITS +: TIMER_BITS]);
                    default: rd_val = {29'b0, done[c], running[c], idle[c]};
                endcase
            end
        end
    end

    // ready pulses once per access; rdata holds between accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready     <= 1'b0;
            rdata     <= '0;
            reset_out <= 1'b1;
        end else begin
            reset_out <= 1'b0;
            ready     <= access;
            if (access) begin
                rdata <= rd_val;
            end
        end
    end

endmodule
